// File: rtl/fetch_buffer_pkg.sv
// Shared CPU definitions used by the fetch path.
// Holds the PC reset value, the legal fetch window, the NOP encoding and the
// fetch-buffer entry layout, plus a helper that builds a buffer entry.
package fetch_buffer_pkg;

  // Architectural PC reset value; the fetch window starts at the same address.
  localparam logic [31:0] PC_RESET         = 32'h0000_3000;

  // Legal fetch window, both bounds inclusive.
  localparam logic [31:0] PC_BASE_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEFAULT = 32'h0000_6FFC;

  // Instruction word substituted for any fetch that faults.
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  // One slot of the fetch buffer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fb_entry_t;

  // A faulting fetch keeps its own PC but never carries the fetched word
  // downstream, so decode sees a NOP tagged with the fault.
  function automatic fb_entry_t make_entry(input logic [31:0] pc,
                                           input logic [31:0] instr,
                                           input logic        exc);
    fb_entry_t e;
    e.pc    = pc;
    e.instr = exc ? INSTR_NOP : instr;
    e.exc   = exc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_pc_check.sv
// pc_check: combinational fetch-address fault detector.
// Latency: zero (pure combinational); no backpressure involvement.
// Ports: pc (fetch address in), exc (1 = misaligned or outside [BASE, LIMIT]).
module pc_check
  import fetch_buffer_pkg::*;
#(
  parameter logic [31:0] BASE  = PC_BASE_DEFAULT,
  parameter logic [31:0] LIMIT = PC_LIMIT_DEFAULT
) (
  input  logic [31:0] pc,
  output logic        exc
);

  logic misaligned;
  logic below_base;
  logic above_limit;

  assign misaligned  = (pc[1:0] != 2'b00);
  assign below_base  = (pc < BASE);
  assign above_limit = (pc > LIMIT);

  assign exc = misaligned || below_base || above_limit;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: flip-flop FIFO of {pc, instr, exc} between fetch and decode.
// Latency: a push in cycle N is visible at out_* in cycle N+1 (no empty bypass).
// Backpressure: in_ready = not full, from registered count only; when full a
//   same-cycle pop does not free a slot for the push. flush empties the buffer.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush               - discard all entries (redirect), beats push/pop
//   in_valid/in_ready   - fetch handshake, in_pc/in_instr carried with it
//   out_valid/out_ready - decode handshake, head entry on out_pc/out_instr/out_exc
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_BASE  = PC_BASE_DEFAULT,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc,
  input  logic        out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             in_exc;
  fb_entry_t        in_entry;
  fb_entry_t        head;
  logic             push;
  logic             pop;

  // Fault classification happens on the way in, so the stored entry is final.
  pc_check #(
    .BASE  (PC_BASE),
    .LIMIT (PC_LIMIT)
  ) u_pc_check (
    .pc  (in_pc),
    .exc (in_exc)
  );

  assign in_entry = make_entry(in_pc, in_instr, in_exc);

  // Both handshake outputs come straight from the count register, which keeps
  // out_ready off the in_ready path (and forbids push-into-freed-slot when full).
  assign in_ready  = (count < CNT_FULL);
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Storage is reset to zero, so the head reads as zero rather than X when empty.
  assign head      = mem[rd_ptr];
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_exc   = head.exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Entries are abandoned, not cleared: slot contents only change on push.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        out_ready;

  int checks;
  int failures;

  fetch_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] pc_i;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_instr  = 32'h0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_exc", out_exc, 0);

    // Single push, visible next cycle, popped the cycle after
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3C01_1234; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("one_valid", out_valid, 1);
    check("one_pc", out_pc, 32'h3000);
    check("one_instr", out_instr, 32'h3C01_1234);
    check("one_exc", out_exc, 0);
    step();
    check("one_drained", out_valid, 0);

    // Fill with decode stalled, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'hAAAA_0001;
    step();
    check("fill1_in_ready", in_ready, 1);
    check("fill1_valid", out_valid, 1);
    in_pc = 32'h3004; in_instr = 32'hAAAA_0002;
    step();
    in_valid = 1'b0;
    check("fill2_in_ready", in_ready, 0);
    check("fill2_head_pc", out_pc, 32'h3000);
    step();
    check("stall_hold_pc", out_pc, 32'h3000);
    check("stall_hold_instr", out_instr, 32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    check("drain1_pc", out_pc, 32'h3004);
    check("drain1_instr", out_instr, 32'hAAAA_0002);
    check("drain1_in_ready", in_ready, 1);
    step();
    check("drain2_empty", out_valid, 0);

    // Full: push attempt with simultaneous pop -> only the pop happens
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3008; in_instr = 32'hC0C0_0008;
    step();
    in_pc = 32'h300C; in_instr = 32'hC0C0_000C;
    step();
    check("full_in_ready", in_ready, 0);
    in_pc = 32'h3010; in_instr = 32'hC0C0_0010; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("fullpop_in_ready", in_ready, 1);
    check("fullpop_valid", out_valid, 1);
    check("fullpop_pc", out_pc, 32'h300C);
    out_ready = 1'b1;
    step();
    check("fullpop_no_push", out_valid, 0);

    // Address faults: misaligned, below base, above limit, then top legal word
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3002; in_instr = 32'hFFFF_FFFF;
    step();
    check("mis_exc", out_exc, 1);
    check("mis_instr", out_instr, 0);
    check("mis_pc", out_pc, 32'h3002);
    out_ready = 1'b1; in_pc = 32'h2FFC; in_instr = 32'h1111_1111;
    step();
    check("low_pc", out_pc, 32'h2FFC);
    check("low_exc", out_exc, 1);
    check("low_instr", out_instr, 0);
    in_pc = 32'h7000; in_instr = 32'h2222_2222;
    step();
    check("high_pc", out_pc, 32'h7000);
    check("high_exc", out_exc, 1);
    check("high_instr", out_instr, 0);
    in_pc = 32'h6FFC; in_instr = 32'h1234_5678;
    step();
    check("limit_pc", out_pc, 32'h6FFC);
    check("limit_exc", out_exc, 0);
    check("limit_instr", out_instr, 32'h1234_5678);
    in_valid = 1'b0;
    step();
    check("fault_drained", out_valid, 0);

    // Flush beats a simultaneous push and pop
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3020; in_instr = 32'hF1F1_0020;
    step();
    in_pc = 32'h3024; in_instr = 32'hF1F1_0024;
    step();
    flush = 1'b1; in_pc = 32'h3010; in_instr = 32'hBAD0_3010; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    in_valid = 1'b1; in_pc = 32'h3030; in_instr = 32'hF1F1_0030;
    step();
    in_valid = 1'b0;
    check("post_flush_pc", out_pc, 32'h3030);
    check("post_flush_instr", out_instr, 32'hF1F1_0030);
    out_ready = 1'b1;
    step();
    check("post_flush_empty", out_valid, 0);

    // Streaming push+pop for 20 cycles, pointers wrap repeatedly
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc_i     = 32'h3000 + 32'(4 * i);
      in_pc    = pc_i;
      in_instr = 32'h5000_0000 + 32'(i);
      step();
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, pc_i);
      check("stream_instr", out_instr, 32'h5000_0000 + 32'(i));
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", out_valid, 0);

    // Reset mid-operation discards entries and clears storage
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3040; in_instr = 32'h7777_0040;
    step();
    in_pc = 32'h3044; in_instr = 32'h7777_0044;
    step();
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_pc", out_pc, 0);
    check("midrst_instr", out_instr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
